// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width and the IDLE/LOAD/WAIT state encoding
// used by the TX arbiter and the TX/RX FSMs.
package uart_pkg;

  localparam int UART_DBIT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Rotate so ptr sits at bit 0, priority-encode the lowest set bit, then unrotate.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  logic [NUM_REQ-1:0] rotated;
  logic [PW-1:0]      offset;
  logic [PW:0]        sum;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rotated = NUM_REQ'({req, req} >> ptr);
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = PW'(k);
    end
    valid = |req;
    sum   = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PW + 1)'(NUM_REQ)) idx = PW'(sum - (PW + 1)'(NUM_REQ));
    else                           idx = sum[PW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to build the baud_tick watchdog that aborts a hung frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DBIT          = UART_DBIT,
  parameter int TIMEOUT_TICKS = 256,
  parameter int TW            = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    baud_tick,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*DBIT-1:0] req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PW = $clog2(NUM_REQ);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] next_ptr;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The requester after the one just served gets first look next time.
  assign next_ptr = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TW-1:0] wd;
`else
  logic unused_cfg;
  assign unused_cfg  = baud_tick ^ (TIMEOUT_TICKS > TW);
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd          <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            sel      <= pick_idx;
            tx_din   <= req_data[int'(pick_idx)*DBIT +: DBIT];
            gnt      <= NUM_REQ'(1) << pick_idx;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the same cycle as the final tick completes the frame normally.
          if (tx_done_tick) begin
            ptr   <= next_ptr;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (baud_tick) begin
            if (wd == TW'(TIMEOUT_TICKS - 1)) begin
              timeout_err <= 1'b1;
              ptr         <= next_ptr;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else begin
              wd <= wd + TW'(1);
            end
          end
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus directed scenarios
// and a randomized phase; the model follows UART_TX_ARB_TIMEOUT_EN like the design.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DBIT    = 8;
  localparam int TO      = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    baud_tick = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*DBIT-1:0] req_data = '0;
  logic [NUM_REQ-1:0]      gnt;
  logic                    tx_start;
  logic [DBIT-1:0]         tx_din;
  logic                    tx_done_tick = 1'b0;
  logic                    busy;
  logic                    timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DBIT(DBIT), .TIMEOUT_TICKS(TO), .TW(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int dut_log[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a frame is either absent, just granted (start cycle), or in flight awaiting done/timeout.
  bit                 m_active, m_loading;
  int                 m_ptr, m_owner, m_ticks;
  logic [NUM_REQ-1:0] e_gnt;
  logic               e_start, e_busy, e_err;
  logic [DBIT-1:0]    e_din;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_loading = 0; m_ptr = 0; m_owner = 0; m_ticks = 0;
      e_gnt = '0; e_start = 0; e_busy = 0; e_err = 0; e_din = '0;
    end else begin
      e_gnt = '0; e_start = 0; e_err = 0;
      if (!m_active) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int j;
          j = (m_ptr + k) % NUM_REQ;
          if (req[j] && !m_active) begin
            m_active = 1; m_loading = 1; m_owner = j;
            e_din = req_data[j*DBIT +: DBIT];
            e_gnt = NUM_REQ'(1 << j);
            e_start = 1; e_busy = 1;
          end
        end
      end else if (m_loading) begin
        m_loading = 0; m_ticks = 0;
      end else if (tx_done_tick) begin
        m_ptr = (m_owner + 1) % NUM_REQ; m_active = 0; e_busy = 0;
      end else if (WD_ON && baud_tick) begin
        m_ticks++;
        if (m_ticks == TO) begin
          m_ptr = (m_owner + 1) % NUM_REQ; m_active = 0; e_busy = 0; e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("tx_start", 32'(tx_start), 32'(e_start));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_err));
    check("tx_din", 32'(tx_din), 32'(e_din));
    if (tx_start) start_cnt++;
    if (timeout_err) err_cnt++;
    if (gnt != '0) begin
      gnt_cnt++;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) dut_log.push_back(i);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; req = '0; tx_done_tick = 0; baud_tick = 0;
    step(2);
    reset = 1'b1;
  endtask

  // Act as the TX core: wait (bounded) for tx_start, then finish the frame after delay cycles.
  task automatic serve(input int delay);
    int n = 0;
    while (!tx_start && n < 50) begin step(); n++; end
    if (!tx_start) begin
      checks++; errors++;
      $display("FAIL serve_wait: got no tx_start expected one within 50 cycles");
      return;
    end
    step(delay);
    tx_done_tick = 1; step(); tx_done_tick = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected one before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    int exp2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e0, n;

    // 1: single request, capture and hold
    reset = 0; #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_din", 32'(tx_din), 0);
    apply_reset();
    req = 4'b0100; req_data = 32'h11A5_2233;
    step();
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_start", 32'(tx_start), 1);
    check("t1_din", 32'(tx_din), 32'hA5);
    req = '0; req_data = 32'hFFFF_FFFF;
    step();
    check("t1_gnt_drop", 32'(gnt), 0);
    step(3);
    check("t1_din_hold", 32'(tx_din), 32'hA5);
    check("t1_busy", 32'(busy), 1);
    tx_done_tick = 1; step(); tx_done_tick = 0;
    check("t1_idle", 32'(busy), 0);

    // 2: all requesters held for eight frames
    apply_reset();
    dut_log.delete();
    req = 4'hF;
    for (int f = 0; f < 8; f++) serve(1 + f % 3);
    req = '0;
    step(2);
    check("t2_count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_order%0d", i), (i < dut_log.size()) ? dut_log[i] : -1, exp2[i]);

    // 3: stray done in IDLE and LOAD, requester dropping before selection
    apply_reset();
    tx_done_tick = 1; step(); tx_done_tick = 0; step();
    check("t3_idle_done", 32'(busy), 0);
    req = 4'b0001; step();
    check("t3_load", 32'(tx_start), 1);
    tx_done_tick = 1; step(); tx_done_tick = 0; req = '0;
    check("t3_load_done", 32'(busy), 1);
    step(2);
    check("t3_wait", 32'(busy), 1);
    req = 4'b0110; step();
    req = 4'b0100; tx_done_tick = 1; step(); tx_done_tick = 0;
    step();
    check("t3_skip", 32'(gnt), 32'h4);
    req = '0; serve(1);

    // 4: asynchronous reset in WAIT, restart from ptr 0
    apply_reset();
    req = 4'b0001; step(); req = '0; step(2);
    #2 reset = 0; #1;
    check("t4_gnt", 32'(gnt), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_din", 32'(tx_din), 0);
    check("t4_start", 32'(tx_start), 0);
    req = 4'b1010;
    @(posedge clk); #1 reset = 1;
    step();
    check("t4_first", 32'(gnt), 32'h2);
    req = '0; serve(2);

    // 5/6: hung transmitter; watchdog aborts only when built in
    apply_reset();
    req = 4'b0001; step(); req = '0; step();
    e0 = err_cnt;
    for (int t = 0; t < TO; t++) begin
      baud_tick = 1; step(); baud_tick = 0; step(2);
    end
    step();
    check("t5_pulses", err_cnt - e0, WD_ON ? 1 : 0);
    check("t5_busy", 32'(busy), WD_ON ? 0 : 1);
    req = 4'b0011; tx_done_tick = 1; step(); tx_done_tick = 0;
    n = 0;
    while (!tx_start && n < 10) begin step(); n++; end
    check("t5_next", 32'(gnt), 32'h2);
    req = '0; serve(1);

    // randomized traffic
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      req = NUM_REQ'($urandom);
      req_data = $urandom;
      tx_done_tick = ($urandom_range(0, 5) == 0);
      baud_tick = ($urandom_range(0, 2) == 0);
      step();
    end
    req = '0; tx_done_tick = 0; baud_tick = 0;
    step(3);
    check("start_eq_gnt", start_cnt, gnt_cnt);
    check("rand_grants", 32'(gnt_cnt > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
